// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor: start request, operands,
// busy/done handshake and the arithmetic flags fed to the status register.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf, zero, neg
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf, zero, neg
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: A - B computed LSB first as A + ~B + 1 through one
// full-adder cell with a registered carry; flags latched on the final bit.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_subtractor_if.slave    bus
);
  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             carry_nxt;
  logic             sum_bit;
  logic             nb0;
  logic             a_msb;
  logic             b_msb;
  logic             borrow_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             accept;
  logic             last_bit;

  // Single full-adder cell on the current operand LSBs with B inverted.
  assign nb0       = ~b_sh[0];
  assign sum_bit   = a_sh[0] ^ nb0 ^ carry;
  assign carry_nxt = (a_sh[0] & nb0) | (a_sh[0] & carry) | (nb0 & carry);
  assign res_nxt   = {sum_bit, res_sh};

  assign accept   = (state != RUN) && bus.start;
  assign last_bit = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand shifting and result capture; results hold outside the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else if (accept) begin
      a_sh  <= bus.a;
      b_sh  <= bus.b;
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
      carry <= 1'b1;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt[WIDTH-1:1];
      carry  <= carry_nxt;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        diff_q   <= res_nxt;
        borrow_q <= ~carry_nxt;
        ovf_q    <= (a_msb != b_msb) && (sum_bit != a_msb);
        zero_q   <= (res_nxt == '0);
        neg_q    <= sum_bit;
      end
    end
  end

  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
endmodule
